fifo_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/mem_dp_param.sv | 33 +++
 rtl/fifo_param.sv | 90 +++++++++
 tb/tb_fifo_param.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults for the transaction-layer FIFO
package fifo_pkg;

  localparam int DEF_DATA_WIDTH      = 12;
  localparam int DEF_ADDR_WIDTH      = 3;
  localparam int DEF_ALMOST_FULL_TH  = 6;
  localparam int DEF_ALMOST_EMPTY_TH = 2;

  // Occupancy needs one bit more than the pointers to represent DEPTH itself.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEF_COUNT_WIDTH = count_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/mem_dp_param.sv
// rtl/mem_dp_param.sv - dual-address RAM, one write port and one registered read port
module mem_dp_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  // Same-edge read and write of one address returns the old entry.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - synchronous FIFO with thresholds; FIFO_ERR_FLAGS_EN enables sticky overflow/underflow
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop_ok, push_ok;

  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign push_ok = push & (~full | pop_ok);

  assign fifo_count   = count;
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(ALMOST_FULL_TH));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_TH));

  mem_dp_param #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (push_ok & ~reset),
    .waddr(wr_ptr),
    .wdata(FIFO_data_in),
    .re   (pop_ok & ~reset),
    .raddr(rd_ptr),
    .rdata(FIFO_data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~push_ok) overflow  <= 1'b1;
      if (pop & ~pop_ok)   underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - queue-model checked bench for fifo_param
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din;
  logic        push, pop;
  logic [11:0] dout;
  logic        data_valid, full, empty, almost_full, almost_empty;
  logic [3:0]  fifo_count;
  logic        overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] q [$];
  logic [11:0] m_out;
  logic        m_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .FIFO_data_in (din),
    .push         (push),
    .pop          (pop),
    .FIFO_data_out(dout),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic eo, eu;
    n = q.size();
`ifdef FIFO_ERR_FLAGS_EN
    eo = m_ovf; eu = m_unf;
`else
    eo = 1'b0;  eu = 1'b0;
`endif
    chk({tag, ".count"},        12'(fifo_count),   12'(n));
    chk({tag, ".empty"},        12'(empty),        12'(n == 0));
    chk({tag, ".full"},         12'(full),         12'(n == 8));
    chk({tag, ".almost_full"},  12'(almost_full),  12'(n >= 6));
    chk({tag, ".almost_empty"}, 12'(almost_empty), 12'(n <= 2));
    chk({tag, ".data_out"},     dout,              m_out);
    chk({tag, ".data_valid"},   12'(data_valid),   12'(m_valid));
    chk({tag, ".overflow"},     12'(overflow),     12'(eo));
    chk({tag, ".underflow"},    12'(underflow),    12'(eu));
  endtask

  // Reference: a queue of at most 8 entries; a pop is served before the push lands.
  task automatic model_step(input logic p, input logic o, input logic [11:0] d);
    logic pop_acc, push_acc;
    pop_acc  = o && (q.size() > 0);
    push_acc = p && ((q.size() < 8) || pop_acc);
    m_valid  = pop_acc;
    if (pop_acc) m_out = q.pop_front();
    if (push_acc) q.push_back(d);
    if (p && !push_acc) m_ovf = 1'b1;
    if (o && !pop_acc)  m_unf = 1'b1;
  endtask

  task automatic step(input string tag, input logic p, input logic o, input logic [11:0] d);
    push = p; pop = o; din = d;
    @(posedge clk);
    model_step(p, o, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic p);
    reset = 1'b1; push = p; pop = 1'b0; din = 12'h5A5;
    @(posedge clk);
    q.delete();
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    reset = 1'b0; push = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    do_reset("reset0", 1'b0);
    do_reset("reset1", 1'b0);
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 12'h000);

    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 12'(i));
    step("push_full", 1'b1, 1'b0, 12'hFFF);

    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 12'h000);
    step("pop_empty", 1'b0, 1'b1, 12'h000);
    step("after_pop_empty", 1'b0, 1'b0, 12'h000);

    do_reset("reset_wrap", 1'b0);
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 1'b0, 12'(12'h100 + i));
    for (int i = 3; i < 20; i++) step("wrap", 1'b1, 1'b1, 12'(12'h100 + i));
    for (int i = 0; i < 3; i++) step("wrap_post", 1'b0, 1'b1, 12'h000);

    do_reset("reset_sim", 1'b0);
    for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, 12'($urandom_range(0, 12'hFFE)));
    step("full_push_pop", 1'b1, 1'b1, 12'hABC);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, 12'h000);
    chk("abc_last", dout, 12'hABC);
    step("empty_push_pop", 1'b1, 1'b1, 12'h055);

    do_reset("reset_mid_pre", 1'b0);
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 12'(12'h200 + i));
    step("pop_before_reset", 1'b0, 1'b1, 12'h000);
    step("refill5", 1'b1, 1'b0, 12'h300);
    do_reset("reset_mid", 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset", 1'($urandom));
      else step("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
